axil_bram_slave: RTL and testbench
==================================

Name: axil_bram_slave

Overview:
AXI4-Lite responder (slave) backed by an internal word-addressed memory array. It is the target side of the single-beat master traffic used to exercise on-chip BRAM: it accepts AW/W/B write transactions and AR/R read transactions, and returns data with OKAY or SLVERR responses. Write and read channels run as independent state machines, so one read and one write can be in flight at the same time.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, >= 2.
IDX_W, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
s_axi_awaddr  in  32  write byte address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i]
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  32  read byte address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response: 00 OKAY, 10 SLVERR
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready

Behaviour:
- Reset: reset is rstn, synchronous, active-low, on clock clk. All outputs are registered and reset to 0, including awready, wready, arready, bvalid, rvalid, bresp, rresp and rdata. The memory array is not cleared. awready, wready and arready rise on the first edge with rstn high.
- Address decode: addr[1:0] are ignored and the word index is addr[IDX_W+1:2]. An address is in range iff addr < DEPTH*4.
- Write FSM:
  - WR_IDLE: awready and wready are independent. An AW handshake (awvalid & awready) captures awaddr and drops awready. A W handshake captures wdata and wstrb and drops wready. AW and W may arrive in either order or in the same cycle. Once both are held, go to WR_COMMIT.
  - WR_COMMIT (1 cycle): both readies are 0. If in range, write the bytes whose wstrb bit is set and set bresp=00. If out of range, suppress the write and set bresp=10. Set bvalid=1 and go to WR_RESP.
  - WR_RESP: hold bvalid and bresp until bready. On the handshake edge, bvalid<=0, awready<=1, wready<=1, and return to WR_IDLE.
  - Latency: bvalid is high 2 cycles after the later of the AW and W handshakes. bready held high means a new AW can be accepted 1 cycle after the B handshake.
  - wstrb=0000 is a legal no-op write and still returns OKAY.
- Read FSM:
  - RD_IDLE: arready=1. An AR handshake captures araddr, drops arready, and goes to RD_FETCH.
  - RD_FETCH (1 cycle): registered memory read. If in range, rdata<=mem[idx] and rresp=00. If out of range, rdata<=0 and rresp=10. Set rvalid=1 and go to RD_DATA.
  - RD_DATA: hold rvalid, rdata and rresp stable until rready. On the handshake, rvalid<=0, arready<=1, and return to RD_IDLE.
  - Latency: rvalid is high 2 cycles after the AR handshake.
- Simultaneous events:
  - A WR_COMMIT and an RD_FETCH on the same word in the same cycle return the old data (read-before-write).
  - A read issued after bvalid was observed returns the new data.
- Stalls: a master that withholds bready or rready stalls only its own channel. The other channel keeps operating.
- Reset mid-transaction: all captured address/data is discarded and both FSMs return to IDLE. A write not yet in WR_COMMIT is never committed. Pending bvalid and rvalid drop to 0 without a handshake.

Optional Feature:
AXIL_ADDR_WRAP_EN
- Defined: out-of-range addresses wrap. idx = addr[IDX_W+1:2] regardless of the upper bits, every access is committed or read, and bresp/rresp are always 00.
- Undefined: the out-of-range SLVERR behaviour above applies.

Test Plan:
1. Write 0x0000000F to 0x4 with wstrb 1111 (AW then W the next cycle), then read 0x4 -> bresp 00; bvalid 2 cycles after the W handshake; rdata 0x0000000F; rresp 00; rvalid 2 cycles after the AR handshake.
2. Write 0xAABBCCDD to 0x8, then write 0x11223344 to 0x8 with wstrb 0101, then read 0x8 -> rdata 0xAA22CC44.
3. Write 0xDEADBEEF to 0x0. Present AW and W in the same cycle with wdata 0x12345678 to 0x0, and issue AR 0x0 so its RD_FETCH coincides with WR_COMMIT -> rdata 0xDEADBEEF. A following read of 0x0 -> 0x12345678.
4. Write to DEPTH*4 (0x400 at default) -> bresp 10 and no memory change. Read 0x400 -> rresp 10, rdata 0. With AXIL_ADDR_WRAP_EN -> both responses 00, and word 0 is written and read back.
5. Hold bready=0 for 5 cycles after bvalid while doing a read of 0x4 -> the read completes normally; bvalid and bresp stay stable; awready stays 0 until the B handshake.
6. Assert rstn=0 for 1 cycle after the AW handshake but before W -> all outputs 0 for that cycle; the readies return to 1; a later read of that address returns its previous contents.

Source files
------------

// File: rtl/axil_bram_slave.sv
// AXI4-Lite responder backed by a word-addressed memory; independent write and read FSMs.
// Define AXIL_ADDR_WRAP_EN to make out-of-range addresses wrap onto the array instead of answering SLVERR.
module axil_bram_slave #(
  parameter int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_DATA} rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             aw_ok, ar_ok;
  logic             aw_held, w_held;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic             aw_hs, w_hs, ar_hs;
  logic             aw_in, ar_in;
  logic             unused_addr_bits;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // Range is decided at capture time so only the flag and the index need storing.
`ifdef AXIL_ADDR_WRAP_EN
  assign aw_in = 1'b1;
  assign ar_in = 1'b1;
`else
  assign aw_in = (s_axi_awaddr >> (IDX_W + 2)) == 32'd0;
  assign ar_in = (s_axi_araddr >> (IDX_W + 2)) == 32'd0;
`endif
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_state      <= WR_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      aw_ok         <= 1'b0;
      w_data        <= '0;
      w_strb        <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs) begin
            aw_idx  <= s_axi_awaddr[IDX_W+1:2];
            aw_ok   <= aw_in;
            aw_held <= 1'b1;
          end
          if (w_hs) begin
            w_data <= s_axi_wdata;
            w_strb <= s_axi_wstrb;
            w_held <= 1'b1;
          end
          // Ready stays up only while that half of the transaction is still missing.
          s_axi_awready <= !(aw_held | aw_hs);
          s_axi_wready  <= !(w_held | w_hs);
          if ((aw_held | aw_hs) && (w_held | w_hs))
            wr_state <= WR_COMMIT;
        end
        WR_COMMIT: begin
          s_axi_bresp  <= aw_ok ? 2'b00 : 2'b10;
          s_axi_bvalid <= 1'b1;
          aw_held      <= 1'b0;
          w_held       <= 1'b0;
          wr_state     <= WR_RESP;
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            wr_state      <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Memory has no reset; the read in RD_FETCH sees the pre-commit value on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (rstn && wr_state == WR_COMMIT && aw_ok) begin
      for (int i = 0; i < 4; i++)
        if (w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_state      <= RD_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= 2'b00;
      s_axi_rdata   <= '0;
      ar_idx        <= '0;
      ar_ok         <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          s_axi_arready <= !ar_hs;
          if (ar_hs) begin
            ar_idx   <= s_axi_araddr[IDX_W+1:2];
            ar_ok    <= ar_in;
            rd_state <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          s_axi_rdata  <= ar_ok ? mem[ar_idx] : 32'd0;
          s_axi_rresp  <= ar_ok ? 2'b00 : 2'b10;
          s_axi_rvalid <= 1'b1;
          rd_state     <= RD_DATA;
        end
        RD_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            rd_state      <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_bram_slave.sv
// Self-checking bench for axil_bram_slave: table of write/readback vectors plus hand-built
// sequences for collisions, out-of-range access, B-channel stall and mid-transaction reset.
`timescale 1ns/1ps
module tb_axil_bram_slave;
  localparam int DEPTH = 256;
`ifdef AXIL_ADDR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;

  axil_bram_slave #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          w_delay;
    logic [31:0] exp_rdata;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  rsp_t        exp_r[$];
  logic [1:0]  exp_b[$];
  logic [31:0] model [DEPTH];
  vec_t        vecs [6];
  logic [31:0] got, got2;

  function automatic bit in_rng(input logic [31:0] a);
    return WRAP || (a < 32'(DEPTH * 4));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'(DEPTH - 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // w_delay 0: AW and W together; otherwise W follows one cycle after the AW handshake.
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_delay);
    int cnt;
    logic [1:0] eb;
    @(posedge clk); #1;
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata = data; s_axi_wstrb = strb;
    if (w_delay == 0) s_axi_wvalid = 1'b1;
    exp_b.push_back(in_rng(addr) ? 2'b00 : 2'b10);
    cnt = 0;
    do begin @(negedge clk); cnt++; end
    while (!(s_axi_awready && (w_delay != 0 || s_axi_wready)) && cnt < 50);
    chk("aw_accept", s_axi_awready, 1'b1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    if (w_delay != 0) begin
      s_axi_wvalid = 1'b1;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!s_axi_wready && cnt < 50);
      chk("w_accept", s_axi_wready, 1'b1);
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!s_axi_bvalid && cnt < 50);
    chk("b_latency", cnt, 2);
    eb = exp_b.pop_front();
    chk("bresp", s_axi_bresp, eb);
    if (in_rng(addr))
      for (int i = 0; i < 4; i++)
        if (strb[i]) model[widx(addr)][8*i +: 8] = data[8*i +: 8];
  endtask

  task automatic read_txn(input logic [31:0] addr, output logic [31:0] rd);
    int cnt;
    rsp_t r;
    @(posedge clk); #1;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    r.data = in_rng(addr) ? model[widx(addr)] : 32'd0;
    r.resp = in_rng(addr) ? 2'b00 : 2'b10;
    exp_r.push_back(r);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!s_axi_arready && cnt < 50);
    chk("ar_accept", s_axi_arready, 1'b1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!s_axi_rvalid && cnt < 50);
    chk("r_latency", cnt, 2);
    r = exp_r.pop_front();
    chk("rdata", s_axi_rdata, r.data);
    chk("rresp", s_axi_rresp, r.resp);
    rd = s_axi_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0004, 32'h0000_000F, 4'b1111, 1, 32'h0000_000F};
    vecs[1] = '{32'h0000_0008, 32'hAABB_CCDD, 4'b1111, 0, 32'hAABB_CCDD};
    vecs[2] = '{32'h0000_0008, 32'h1122_3344, 4'b0101, 1, 32'hAA22_CC44};
    vecs[3] = '{32'h0000_0008, 32'hFFFF_FFFF, 4'b0000, 0, 32'hAA22_CC44};
    vecs[4] = '{32'h0000_03FC, 32'hCAFE_F00D, 4'b1111, 1, 32'hCAFE_F00D};
    vecs[5] = '{32'h0000_0013, 32'h0102_0304, 4'b1111, 0, 32'h0102_0304};

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                       s_axi_rvalid, s_axi_bresp, s_axi_rresp}, 32'd0);
    chk("reset_rdata", s_axi_rdata, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    for (int v = 0; v < 6; v++) begin
      write_txn(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].w_delay);
      read_txn(vecs[v].addr, got);
      chk("vec_readback", got, vecs[v].exp_rdata);
    end

    // Same-cycle commit and fetch on word 0: the read must see the old contents.
    write_txn(32'h0, 32'hDEAD_BEEF, 4'b1111, 1);
    fork
      write_txn(32'h0, 32'h1234_5678, 4'b1111, 0);
      begin read_txn(32'h0, got); chk("rbw_old", got, 32'hDEAD_BEEF); end
    join
    read_txn(32'h0, got);
    chk("after_b_new", got, 32'h1234_5678);

    write_txn(32'(DEPTH * 4), 32'h7777_7777, 4'b1111, 0);
    read_txn(32'(DEPTH * 4), got);
    read_txn(32'h0, got);
    chk("oob_word0", got, WRAP ? 32'h7777_7777 : 32'h1234_5678);

    // Withheld bready stalls only the write channel.
    s_axi_bready = 1'b0;
    fork
      begin
        write_txn(32'h0000_000C, 32'h5A5A_A5A5, 4'b1111, 0);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("b_stall_hold", {s_axi_bvalid, s_axi_bresp, s_axi_awready}, 4'b1000);
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        chk("b_release", {s_axi_bvalid, s_axi_awready}, 2'b01);
      end
      begin read_txn(32'h4, got2); chk("stall_read", got2, 32'h0000_000F); end
    join

    // Reset after the AW handshake, before W: the write must never land.
    @(posedge clk); #1;
    s_axi_awaddr = 32'h4; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'b1111;
    begin
      int cnt;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!s_axi_awready && cnt < 50);
      chk("rst_aw_accept", s_axi_awready, 1'b1);
    end
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ctrl", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                        s_axi_rvalid, s_axi_bresp, s_axi_rresp}, 32'd0);
    chk("midrst_rdata", s_axi_rdata, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    read_txn(32'h4, got);
    chk("midrst_no_commit", got, 32'h0000_000F);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
